mips_mem_responder: RTL and testbench



---
 rtl/mips_mem_pkg.sv | 19 +
 rtl/mips_word_ram.sv | 28 ++
 rtl/mips_mem_responder.sv | 125 ++++++++++++
 tb/tb_mips_mem_responder.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the multicycle MIPS memory responder.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    typedef enum logic [1:0] {
        OP_READ,
        OP_WRITE,
        OP_ILLEGAL
    } op_e;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned BYTE_OFS_W = 2;

endpackage

// File: rtl/mips_word_ram.sv
// Synchronous single-port word array; rdata only updates on a read enable.
module mips_word_ram #(
    parameter int DEPTH_LOG2 = 8,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] r_mem [2**DEPTH_LOG2];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[idx] <= wdata;
        end
        if (re) begin
            r_rdata <= r_mem[idx];
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/mips_mem_responder.sv
// Memory-side responder with WAIT_STATES latency for the multicycle MIPS memory port.
// Optional MEM_ALIGN_CHECK_EN flags misaligned (addr[1:0] != 0) accesses as errors.
module mips_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              err
);

    localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

    state_e              r_state;
    op_e                 r_op;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ready;
    logic                r_err;
    logic                r_rdata_zero;

    logic                  w_oor;
    logic                  w_misalign;
    logic                  w_err;
    logic                  w_we;
    logic                  w_re;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [DATA_W-1:0]     w_ram_rdata;

    assign w_oor = (r_addr >> (DEPTH_LOG2 + BYTE_OFS_W)) != '0;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = r_addr[BYTE_OFS_W-1:0] != '0;
`else
    assign w_misalign = 1'b0;
`endif

    assign w_err = (r_op == OP_ILLEGAL) | w_oor | w_misalign;
    assign w_we  = (r_state == RESP) & (r_op == OP_WRITE) & ~w_err;
    assign w_re  = (r_state == RESP) & (r_op == OP_READ) & ~w_err;
    assign w_idx = r_addr[DEPTH_LOG2+BYTE_OFS_W-1:BYTE_OFS_W];

    mips_word_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (w_we),
        .re    (w_re),
        .idx   (w_idx),
        .wdata (r_wdata),
        .rdata (w_ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_op         <= OP_READ;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_ready      <= 1'b0;
            r_err        <= 1'b0;
            r_rdata_zero <= 1'b1;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (mem_read | mem_write) begin
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        if (mem_read & mem_write) begin
                            r_op    <= OP_ILLEGAL;
                            r_state <= RESP;
                        end else begin
                            r_op <= mem_read ? OP_READ : OP_WRITE;
                            if (WAIT_STATES == 0) begin
                                r_state <= RESP;
                            end else begin
                                r_state <= WAIT;
                                r_cnt   <= CNT_W'(WAIT_STATES - 1);
                            end
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    // RAM access happens on this edge; ready/err show up alongside its rdata.
                    r_ready <= 1'b1;
                    r_err   <= w_err;
                    if (w_err) begin
                        r_rdata_zero <= 1'b1;
                    end else if (r_op == OP_READ) begin
                        r_rdata_zero <= 1'b0;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rdata = r_rdata_zero ? '0 : w_ram_rdata;
    assign ready = r_ready;
    assign err   = r_err;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed scoreboard bench: one responder with 2 wait states, one with 0.
module tb_mips_mem_responder;

    typedef struct {
        string       tag;
        logic [31:0] rd;
        logic        er;
        bit          cd;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mr_s, mw_s, mr_f, mw_f;
    logic [31:0] a_s, wd_s, a_f, wd_f;
    logic [31:0] rd_s, rd_f;
    logic        rdy_s, rdy_f, er_s, er_f;

    always #5 clk = ~clk;

    mips_mem_responder #(.WAIT_STATES(2)) dut_s (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_read  (mr_s),
        .mem_write (mw_s),
        .addr      (a_s),
        .wdata     (wd_s),
        .rdata     (rd_s),
        .ready     (rdy_s),
        .err       (er_s)
    );

    mips_mem_responder #(.WAIT_STATES(0)) dut_f (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_read  (mr_f),
        .mem_write (mw_f),
        .addr      (a_f),
        .wdata     (wd_f),
        .rdata     (rd_f),
        .ready     (rdy_f),
        .err       (er_f)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input bit fast, input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input bit exp_err,
                          input bit chk_data, input string tag);
        exp_t e;
        int   cnt;
        logic rdy;
        e.tag = tag;
        e.rd  = exp_rd;
        e.er  = exp_err;
        e.cd  = chk_data;
        e.lat = (rd && wr) ? 1 : (fast ? 1 : 3);
        sb.push_back(e);
        @(negedge clk);
        if (fast) begin
            mr_f = rd; mw_f = wr; a_f = a; wd_f = wd;
        end else begin
            mr_s = rd; mw_s = wr; a_s = a; wd_s = wd;
        end
        @(posedge clk);
        cnt = 0;
        rdy = 1'b0;
        while (!rdy && cnt < 20) begin
            @(negedge clk);
            if (cnt == 0) begin
                mr_f = 1'b0; mw_f = 1'b0; mr_s = 1'b0; mw_s = 1'b0;
            end
            rdy = fast ? rdy_f : rdy_s;
            if (!rdy) begin
                @(posedge clk);
                cnt++;
            end
        end
        e = sb.pop_front();
        if (!rdy) begin
            chk({e.tag, " ready timeout"}, 32'(rdy), 32'd1);
            return;
        end
        chk({e.tag, " latency"}, 32'(cnt), 32'(e.lat));
        chk({e.tag, " err"}, 32'(fast ? er_f : er_s), 32'(e.er));
        if (e.cd) chk({e.tag, " rdata"}, fast ? rd_f : rd_s, e.rd);
        @(negedge clk);
        chk({e.tag, " ready pulse width"}, 32'(fast ? rdy_f : rdy_s), 32'd0);
        if (e.cd) chk({e.tag, " rdata hold"}, fast ? rd_f : rd_s, e.rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst_n = 1'b0;
        mr_s = 0; mw_s = 0; a_s = 0; wd_s = 0;
        mr_f = 0; mw_f = 0; a_f = 0; wd_f = 0;
        repeat (2) @(negedge clk);
        chk("reset ready", 32'(rdy_s), 32'd0);
        chk("reset err", 32'(er_s), 32'd0);
        chk("reset rdata", rd_s, 32'd0);
        rst_n = 1'b1;

        do_req(0, 0, 1, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1, "wr 0x10");
        do_req(0, 1, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1, "rd 0x10");

        do_req(0, 0, 1, 32'h20, 32'hCAFEF00D, 32'h0, 0, 0, "wr 0x20");
        do_req(0, 1, 1, 32'h20, 32'h11111111, 32'h0, 1, 1, "illegal 0x20");
        do_req(0, 1, 0, 32'h20, 32'h0, 32'hCAFEF00D, 0, 1, "rd 0x20 after illegal");

        do_req(0, 0, 1, 32'h0, 32'hA5A5A5A5, 32'h0, 0, 0, "wr 0x0");
        do_req(0, 0, 1, 32'h400, 32'h5A5A5A5A, 32'h0, 1, 1, "wr oor 0x400");
        do_req(0, 1, 0, 32'h0, 32'h0, 32'hA5A5A5A5, 0, 1, "rd 0x0 after oor");

        do_req(0, 0, 1, 32'h10, 32'h76543210, 32'h0, 0, 0, "wr 0x10 again");
`ifdef MEM_ALIGN_CHECK_EN
        do_req(0, 1, 0, 32'h13, 32'h0, 32'h0, 1, 1, "rd misaligned 0x13");
`else
        do_req(0, 1, 0, 32'h13, 32'h0, 32'h76543210, 0, 1, "rd misaligned 0x13");
`endif
        do_req(0, 1, 0, 32'h0, 32'h0, 32'hA5A5A5A5, 0, 1, "rd 0x0 before reset");

        // Reset while the slow responder sits in WAIT.
        @(negedge clk);
        mr_s = 1'b1; a_s = 32'h0;
        @(posedge clk);
        @(negedge clk);
        mr_s = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("mid-wait reset ready", 32'(rdy_s), 32'd0);
        chk("mid-wait reset err", 32'(er_s), 32'd0);
        chk("mid-wait reset rdata", rd_s, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rdy_s) seen = 1'b1;
        end
        chk("no response after reset", 32'(seen), 32'd0);
        do_req(0, 1, 0, 32'h4, 32'h0, 32'h0, 0, 0, "rd unwritten 0x4");

        do_req(1, 0, 1, 32'h0, 32'h12345678, 32'h0, 0, 0, "ws0 wr 0x0");
        do_req(1, 1, 0, 32'h0, 32'h0, 32'h12345678, 0, 1, "ws0 rd 0x0");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
